port_ingress_writer: RTL and testbench

Per-port ingress writer that fills one input packet RAM read by the switch scheduler. It accepts a 32-bit word stream from a port and writes each packet into the RAM at linearly increasing addresses. It publishes the write pointer (`input_ram_wr_add`) only at packet boundaries, so the scheduler never starts on a partial packet. One instance is built per input port (four in total), driving `input_ram_wr_addN` for the scheduler.

---
 rtl/port_ingress_writer.sv | 113 +++++++++++
 tb/tb_port_ingress_writer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/port_ingress_writer.sv
// Per-port ingress writer: streams packets linearly into the input packet RAM and
// publishes the write pointer to the scheduler only once a whole packet is stored.
//
// state  | meaning
// S_IDLE | between packets; zero words skipped, non-zero word starts a packet
// S_BODY | storing payload until the zero terminator commits the packet
// S_DROP | packet rejected; consume words until its terminator
module port_ingress_writer #(
   parameter int ADDR_W        = 12,
   parameter int MAX_PKT_WORDS = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [31:0]       ram_wr_data,
   output logic [ADDR_W-1:0] input_ram_wr_add,
   output logic [15:0]       pkt_count,
   output logic [15:0]       drop_count
);

   localparam logic [ADDR_W-1:0] PTR_FULL = '1;
   localparam int                LEN_W    = $clog2(MAX_PKT_WORDS + 1);

   typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] cm_ptr;
   logic [ADDR_W-1:0] free_space;
   logic [LEN_W-1:0]  len;
   logic              accept;
   logic              word_zero;
   logic              body_drop;

   assign free_space = PTR_FULL - wr_ptr;
   assign accept     = in_valid && in_ready;
   assign word_zero  = (in_data == 32'd0);
   // Non-zero word must leave room for the terminator, both in length and in RAM.
   assign body_drop  = !word_zero &&
                       ((len == LEN_W'(MAX_PKT_WORDS - 1)) || (free_space == ADDR_W'(1)));

   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state)
            S_IDLE:  in_ready = (free_space >= ADDR_W'(2));
            S_BODY:  in_ready = 1'b1;
            S_DROP:  in_ready = 1'b1;
            default: in_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         wr_ptr           <= '0;
         cm_ptr           <= '0;
         len              <= '0;
         ram_wr_en        <= 1'b0;
         ram_wr_addr      <= '0;
         ram_wr_data      <= '0;
         input_ram_wr_add <= '0;
         pkt_count        <= '0;
         drop_count       <= '0;
      end else begin
         ram_wr_en        <= 1'b0;
         // One-cycle lag keeps the pointer behind the terminator's RAM write.
         input_ram_wr_add <= cm_ptr;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (!word_zero) begin
                     ram_wr_en   <= 1'b1;
                     ram_wr_addr <= wr_ptr;
                     ram_wr_data <= in_data;
                     wr_ptr      <= wr_ptr + ADDR_W'(1);
                     len         <= LEN_W'(1);
                     state       <= S_BODY;
                  end
               end
               S_BODY: begin
                  if (body_drop) begin
                     wr_ptr <= cm_ptr;
                     if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                     state  <= S_DROP;
                  end else begin
                     ram_wr_en   <= 1'b1;
                     ram_wr_addr <= wr_ptr;
                     ram_wr_data <= in_data;
                     wr_ptr      <= wr_ptr + ADDR_W'(1);
                     len         <= len + LEN_W'(1);
                     if (word_zero) begin
                        cm_ptr <= wr_ptr + ADDR_W'(1);
                        if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
                        state  <= S_IDLE;
                     end
                  end
               end
               S_DROP: begin
                  if (word_zero) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_port_ingress_writer.sv
// Directed bench for port_ingress_writer: a vector table for the packet flows plus
// hand sequences for buffer exhaustion, reset mid-packet and stalled input.
module tb_port_ingress_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        tb_reset = 1'b1;
   logic        tb_valid = 1'b0;
   logic [31:0] tb_data  = '0;
   int          sel      = 0;

   // dut0: ADDR_W=5, MAX_PKT_WORDS=4 ; dut1: ADDR_W=3, MAX_PKT_WORDS=8
   logic        v0, v1;
   logic        rdy0, rdy1, we0, we1;
   logic [4:0]  wa0, cm0;
   logic [2:0]  wa1, cm1;
   logic [31:0] wd0, wd1;
   logic [15:0] pc0, pc1, dc0, dc1;

   assign v0 = tb_valid && (sel == 0);
   assign v1 = tb_valid && (sel == 1);

   port_ingress_writer #(.ADDR_W(5), .MAX_PKT_WORDS(4)) dut0 (
      .clk(clk), .reset(tb_reset), .in_valid(v0), .in_data(tb_data), .in_ready(rdy0),
      .ram_wr_en(we0), .ram_wr_addr(wa0), .ram_wr_data(wd0),
      .input_ram_wr_add(cm0), .pkt_count(pc0), .drop_count(dc0));

   port_ingress_writer #(.ADDR_W(3), .MAX_PKT_WORDS(8)) dut1 (
      .clk(clk), .reset(tb_reset), .in_valid(v1), .in_data(tb_data), .in_ready(rdy1),
      .ram_wr_en(we1), .ram_wr_addr(wa1), .ram_wr_data(wd1),
      .input_ram_wr_add(cm1), .pkt_count(pc1), .drop_count(dc1));

   logic        cur_rdy, cur_we;
   logic [31:0] cur_a, cur_wd, cur_cm, cur_pc, cur_dc;
   always_comb begin
      cur_rdy = rdy0; cur_we = we0; cur_a = 32'(wa0); cur_wd = wd0;
      cur_cm  = 32'(cm0); cur_pc = 32'(pc0); cur_dc = 32'(dc0);
      if (sel == 1) begin
         cur_rdy = rdy1; cur_we = we1; cur_a = 32'(wa1); cur_wd = wd1;
         cur_cm  = 32'(cm1); cur_pc = 32'(pc1); cur_dc = 32'(dc1);
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic rdy_s;
   // One clock: drive at negedge, sample in_ready before the edge, outputs #1 after it.
   task automatic step(input logic rst, input logic v, input logic [31:0] d);
      @(negedge clk);
      tb_reset = rst; tb_valid = v; tb_data = d;
      #1 rdy_s = cur_rdy;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic rst; logic v; logic [31:0] d;
      logic rdy; logic we; logic [31:0] a; logic [31:0] wd;
      logic [31:0] cm; logic [31:0] pc; logic [31:0] dc;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic v, input logic [31:0] d,
                               input logic rdy, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] cm,
                               input logic [31:0] pc, input logic [31:0] dc);
      vec_t t;
      t.rst = rst; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a; t.wd = wd;
      t.cm = cm; t.pc = pc; t.dc = dc;
      return t;
   endfunction

   vec_t        vq[$];
   logic [31:0] mem[32];
   int          n_wr;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // single packet
      vq.push_back(mk(1,0,0,            0,0,0,0,            0,0,0));
      vq.push_back(mk(0,1,'h102,        1,1,0,'h102,        0,0,0));
      vq.push_back(mk(0,1,'hAAAA0001,   1,1,1,'hAAAA0001,   0,0,0));
      vq.push_back(mk(0,1,0,            1,1,2,0,            0,1,0));
      vq.push_back(mk(0,0,0,            1,0,0,0,            3,1,0));
      vq.push_back(mk(0,0,0,            1,0,0,0,            3,1,0));
      // leading zeros, then back-to-back 3-word and 4-word packets
      vq.push_back(mk(1,0,0,            0,0,0,0,            0,0,0));
      vq.push_back(mk(0,1,0,            1,0,0,0,            0,0,0));
      vq.push_back(mk(0,1,0,            1,0,0,0,            0,0,0));
      vq.push_back(mk(0,1,'h11,         1,1,0,'h11,         0,0,0));
      vq.push_back(mk(0,1,'h22,         1,1,1,'h22,         0,0,0));
      vq.push_back(mk(0,1,0,            1,1,2,0,            0,1,0));
      vq.push_back(mk(0,1,'h33,         1,1,3,'h33,         3,1,0));
      vq.push_back(mk(0,1,'h44,         1,1,4,'h44,         3,1,0));
      vq.push_back(mk(0,1,'h55,         1,1,5,'h55,         3,1,0));
      vq.push_back(mk(0,1,0,            1,1,6,0,            3,2,0));
      vq.push_back(mk(0,0,0,            1,0,0,0,            7,2,0));
      // oversize packet (MAX_PKT_WORDS=4), then a normal packet from address 0
      vq.push_back(mk(1,0,0,            0,0,0,0,            0,0,0));
      vq.push_back(mk(0,1,'h101,        1,1,0,'h101,        0,0,0));
      vq.push_back(mk(0,1,1,            1,1,1,1,            0,0,0));
      vq.push_back(mk(0,1,2,            1,1,2,2,            0,0,0));
      vq.push_back(mk(0,1,3,            1,0,0,0,            0,0,1));
      vq.push_back(mk(0,1,4,            1,0,0,0,            0,0,1));
      vq.push_back(mk(0,1,5,            1,0,0,0,            0,0,1));
      vq.push_back(mk(0,1,0,            1,0,0,0,            0,0,1));
      vq.push_back(mk(0,1,'h61,         1,1,0,'h61,         0,0,1));
      vq.push_back(mk(0,1,'h62,         1,1,1,'h62,         0,0,1));
      vq.push_back(mk(0,1,0,            1,1,2,0,            0,1,1));
      vq.push_back(mk(0,0,0,            1,0,0,0,            3,1,1));

      sel = 0;
      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].v, vq[i].d);
         chk($sformatf("v%0d in_ready", i), 32'(rdy_s), 32'(vq[i].rdy));
         chk($sformatf("v%0d ram_wr_en", i), 32'(cur_we), 32'(vq[i].we));
         if (vq[i].we || vq[i].rst) begin
            chk($sformatf("v%0d ram_wr_addr", i), cur_a, vq[i].a);
            chk($sformatf("v%0d ram_wr_data", i), cur_wd, vq[i].wd);
         end
         chk($sformatf("v%0d input_ram_wr_add", i), cur_cm, vq[i].cm);
         chk($sformatf("v%0d pkt_count", i), cur_pc, vq[i].pc);
         chk($sformatf("v%0d drop_count", i), cur_dc, vq[i].dc);
      end

      // buffer exhaustion on the 8-word buffer
      sel = 1;
      step(1, 0, 0);
      step(0, 1, 'h10); step(0, 1, 1); step(0, 1, 2); step(0, 1, 3); step(0, 1, 0);
      step(0, 0, 0);
      chk("exh commit5", cur_cm, 5);
      step(0, 1, 'h20);
      chk("exh idle ready free2", 32'(rdy_s), 1);
      chk("exh hdr we", 32'(cur_we), 1);
      chk("exh hdr addr", cur_a, 5);
      step(0, 1, 'h21);
      chk("exh last slot drop we", 32'(cur_we), 0);
      chk("exh drop_count", cur_dc, 1);
      step(0, 1, 0);
      chk("exh drop term we", 32'(cur_we), 0);
      step(0, 0, 0);
      chk("exh ptr held", cur_cm, 5);
      chk("exh ready after drop", 32'(cur_rdy), 1);
      step(0, 1, 'h30);
      chk("exh hdr2 addr", cur_a, 5);
      step(0, 1, 0);
      chk("exh term in last slot we", 32'(cur_we), 1);
      chk("exh term addr", cur_a, 6);
      step(0, 0, 0);
      chk("exh full commit", cur_cm, 7);
      chk("exh full pkt_count", cur_pc, 2);
      chk("exh full ready", 32'(cur_rdy), 0);
      step(0, 1, 'h40);
      chk("exh full ignore we", 32'(cur_we), 0);
      chk("exh full drop_count", cur_dc, 1);

      // reset mid-packet
      sel = 0;
      step(1, 0, 0);
      step(0, 1, 'h101); step(0, 1, 5);
      step(1, 0, 0);
      chk("rst mid ptr", cur_cm, 0);
      chk("rst mid pkt", cur_pc, 0);
      step(0, 0, 0);
      chk("rst mid ptr idle", cur_cm, 0);
      step(0, 1, 7);
      chk("rst next addr", cur_a, 0);
      chk("rst next data", cur_wd, 7);
      step(0, 1, 0);
      chk("rst term addr", cur_a, 1);
      step(0, 0, 0);
      chk("rst next commit", cur_cm, 2);
      chk("rst next pkt", cur_pc, 1);

      // stalled input: RAM image must match the unstalled layout
      begin
         logic [31:0] pkts[7];
         pkts = '{32'h201, 32'hA1, 32'hA2, 32'h0, 32'h302, 32'hB1, 32'h0};
         foreach (mem[k]) mem[k] = 32'hDEADBEEF;
         n_wr = 0;
         step(1, 0, 0);
         for (int w = 0; w < 7; w++) begin
            int stall;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
               step(0, 0, 0);
               if (cur_we) begin mem[cur_a[4:0]] = cur_wd; n_wr++; end
            end
            step(0, 1, pkts[w]);
            if (cur_we) begin mem[cur_a[4:0]] = cur_wd; n_wr++; end
            if (!rdy_s) chk($sformatf("stall word%0d ready", w), 32'(rdy_s), 1);
         end
         for (int s = 0; s < 3; s++) begin
            step(0, 0, 0);
            if (cur_we) begin mem[cur_a[4:0]] = cur_wd; n_wr++; end
         end
         chk("stall write count", 32'(n_wr), 7);
         for (int k = 0; k < 7; k++)
            chk($sformatf("stall mem[%0d]", k), mem[k], pkts[k]);
         chk("stall commit", cur_cm, 7);
         chk("stall pkt_count", cur_pc, 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
